// File: rtl/onehot_pulse_decoder.sv
// Binary index in (valid/ready), one-hot strobe out one cycle after accept, held PULSE_LEN cycles.
// in_ready only in IDLE or on the last DRIVE cycle; ONEHOT_DEC_RANGE_CHECK_EN drops idx >= WIDTH and pulses err.
module onehot_pulse_decoder #(
  parameter int WIDTH     = 8,
  parameter int OUT_BITS  = 3,
  parameter int PULSE_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OUT_BITS-1:0] in_idx,
  output logic [WIDTH-1:0]    out,
  output logic                out_valid,
  output logic                busy,
  output logic                err
);

  localparam int CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_LEN - 1);

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_err, w_err_nxt;

  logic             w_accept;
  logic             w_take;
  logic             w_in_range;
  logic             w_last;
  logic [WIDTH-1:0] w_onehot;

  assign w_last     = (r_cnt == CNT_LAST);
  assign in_ready   = !rst && ((r_state == IDLE) || w_last);
  assign w_accept   = in_valid && in_ready;
  assign w_in_range = (32'(in_idx) < WIDTH);
  assign w_onehot   = w_in_range ? (WIDTH'(1) << in_idx) : '0;

`ifdef ONEHOT_DEC_RANGE_CHECK_EN
  // A dropped index must look exactly like no transfer to the FSM.
  assign w_take    = w_accept && w_in_range;
  assign w_err_nxt = w_accept && !w_in_range;
`else
  assign w_take    = w_accept;
  assign w_err_nxt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_state_nxt = DRIVE;
          w_cnt_nxt   = '0;
          w_out_nxt   = w_onehot;
        end
      end
      DRIVE: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          // Reload on the last cycle keeps back-to-back strobes gap-free.
          if (w_take) begin
            w_out_nxt = w_onehot;
          end else begin
            w_state_nxt = IDLE;
            w_out_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_out_nxt   = '0;
      end
    endcase
  end

  assign out       = r_out;
  assign out_valid = (r_state == DRIVE);
  assign busy      = (r_state == DRIVE);
  assign err       = r_err;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench: instance a (8/3/4), b (PULSE_LEN=1), c (WIDTH=6).
module tb_onehot_pulse_decoder;

  logic       clk;
  logic       rst;

  logic       a_valid, a_ready, a_ovld, a_busy, a_err;
  logic [2:0] a_idx;
  logic [7:0] a_out;

  logic       b_valid, b_ready, b_ovld, b_busy, b_err;
  logic [2:0] b_idx;
  logic [7:0] b_out;

  logic       c_valid, c_ready, c_ovld, c_busy, c_err;
  logic [2:0] c_idx;
  logic [5:0] c_out;

  int n_checks;
  int n_errs;

  onehot_pulse_decoder #(.WIDTH(8), .OUT_BITS(3), .PULSE_LEN(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_idx(a_idx),
    .out(a_out), .out_valid(a_ovld), .busy(a_busy), .err(a_err)
  );

  onehot_pulse_decoder #(.WIDTH(8), .OUT_BITS(3), .PULSE_LEN(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_idx(b_idx),
    .out(b_out), .out_valid(b_ovld), .busy(b_busy), .err(b_err)
  );

  onehot_pulse_decoder #(.WIDTH(6), .OUT_BITS(3), .PULSE_LEN(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_idx(c_idx),
    .out(c_out), .out_valid(c_ovld), .busy(c_busy), .err(c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq_out [3];
  logic [2:0] seq_idx [3];

  initial begin
    n_checks = 0;
    n_errs   = 0;
    rst = 1'b1;
    a_valid = 1'b0; a_idx = '0;
    b_valid = 1'b0; b_idx = '0;
    c_valid = 1'b0; c_idx = '0;
    seq_idx[0] = 3'd0; seq_idx[1] = 3'd7; seq_idx[2] = 3'd3;
    seq_out[0] = 8'h01; seq_out[1] = 8'h80; seq_out[2] = 8'h08;

    // Reset state
    step();
    step();
    check("rst_out", 32'(a_out), 32'h0);
    check("rst_ovld", 32'(a_ovld), 32'h0);
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_err", 32'(a_err), 32'h0);
    check("rst_ready", 32'(a_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("idle_ready", 32'(a_ready), 32'h1);

    // Single strobe, idx 5
    a_valid = 1'b1; a_idx = 3'd5;
    step();
    a_valid = 1'b0; a_idx = 3'd0;
    for (int i = 0; i < 4; i++) begin
      check("single_out", 32'(a_out), 32'h20);
      check("single_ovld", 32'(a_ovld), 32'h1);
      check("single_busy", 32'(a_busy), 32'h1);
      check("single_ready", 32'(a_ready), (i == 3) ? 32'h1 : 32'h0);
      step();
    end
    check("single_end_out", 32'(a_out), 32'h0);
    check("single_end_ovld", 32'(a_ovld), 32'h0);
    check("single_end_ready", 32'(a_ready), 32'h1);

    // Back-to-back 0, 7, 3
    a_valid = 1'b1; a_idx = seq_idx[0];
    step();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        check("b2b_out", 32'(a_out), 32'(seq_out[k]));
        check("b2b_ovld", 32'(a_ovld), 32'h1);
        check("b2b_ready", 32'(a_ready), (i == 3) ? 32'h1 : 32'h0);
        if (i == 3) begin
          if (k < 2) a_idx = seq_idx[k+1];
          else a_valid = 1'b0;
        end
        step();
      end
    end
    check("b2b_end_out", 32'(a_out), 32'h0);
    check("b2b_end_ovld", 32'(a_ovld), 32'h0);

    // Request arriving mid-pulse waits for the last cycle
    a_valid = 1'b1; a_idx = 3'd4;
    step();
    a_valid = 1'b0;
    step();
    a_valid = 1'b1; a_idx = 3'd2;
    check("wait_cnt1_ready", 32'(a_ready), 32'h0);
    check("wait_cnt1_out", 32'(a_out), 32'h10);
    step();
    check("wait_cnt2_ready", 32'(a_ready), 32'h0);
    check("wait_cnt2_out", 32'(a_out), 32'h10);
    step();
    check("wait_cnt3_ready", 32'(a_ready), 32'h1);
    check("wait_cnt3_out", 32'(a_out), 32'h10);
    step();
    a_valid = 1'b0;
    check("wait_new_out", 32'(a_out), 32'h04);
    check("wait_new_ready", 32'(a_ready), 32'h0);
    for (int i = 0; i < 4; i++) step();
    check("wait_end_out", 32'(a_out), 32'h0);

    // Reset mid-pulse, idx 6 at cnt 2
    a_valid = 1'b1; a_idx = 3'd6;
    step();
    a_valid = 1'b0;
    step();
    step();
    check("abort_pre_out", 32'(a_out), 32'h40);
    rst = 1'b1;
    a_valid = 1'b1; a_idx = 3'd1;
    #1;
    check("abort_rst_ready", 32'(a_ready), 32'h0);
    step();
    rst = 1'b0;
    a_valid = 1'b0;
    check("abort_out", 32'(a_out), 32'h0);
    check("abort_ovld", 32'(a_ovld), 32'h0);
    check("abort_busy", 32'(a_busy), 32'h0);
    step();
    check("abort_idle_out", 32'(a_out), 32'h0);
    check("abort_idle_ready", 32'(a_ready), 32'h1);

    // PULSE_LEN = 1 stream 1, 2, 4
    check("p1_idle_ready", 32'(b_ready), 32'h1);
    b_valid = 1'b1; b_idx = 3'd1;
    step();
    check("p1_out0", 32'(b_out), 32'h02);
    check("p1_ready0", 32'(b_ready), 32'h1);
    b_idx = 3'd2;
    step();
    check("p1_out1", 32'(b_out), 32'h04);
    b_idx = 3'd4;
    step();
    check("p1_out2", 32'(b_out), 32'h10);
    check("p1_ovld2", 32'(b_ovld), 32'h1);
    b_valid = 1'b0;
    step();
    check("p1_end_out", 32'(b_out), 32'h0);
    check("p1_end_ovld", 32'(b_ovld), 32'h0);

    // WIDTH = 6: top in-range index, then out-of-range index 7
    c_valid = 1'b1; c_idx = 3'd5;
    step();
    c_valid = 1'b0;
    check("w6_top_out", 32'(c_out), 32'h20);
    for (int i = 0; i < 4; i++) step();
    check("w6_top_end", 32'(c_ovld), 32'h0);
    c_valid = 1'b1; c_idx = 3'd7;
    step();
    c_valid = 1'b0;
`ifdef ONEHOT_DEC_RANGE_CHECK_EN
    check("oor_err", 32'(c_err), 32'h1);
    check("oor_ovld", 32'(c_ovld), 32'h0);
    check("oor_out", 32'(c_out), 32'h0);
    check("oor_ready", 32'(c_ready), 32'h1);
    step();
    check("oor_err_clr", 32'(c_err), 32'h0);
    check("oor_ovld_after", 32'(c_ovld), 32'h0);
`else
    for (int i = 0; i < 4; i++) begin
      check("oor_ovld", 32'(c_ovld), 32'h1);
      check("oor_out", 32'(c_out), 32'h0);
      check("oor_err", 32'(c_err), 32'h0);
      step();
    end
    check("oor_end_ovld", 32'(c_ovld), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
